mul_unit: RTL
=============

// Module: mul_unit
// PURPOSE
//  Iterative shift-add multiplier sequencer serving the EX stage's multiply request interface.
//  - Accepts MUL_START_I, SIGNED_MUL_I, MULTIPLICAND_I, MULTIPLIER_I and MUL_CANCEL_I from EX.
//  - Sequences a multi-cycle computation; while it runs, EX raises its stall request.
//  - Returns MUL_READY_O and the full 2*WIDTH product, from which EX uses the low word.
// PARAMETERS
//  WIDTH           32  operand width; product width is 2*WIDTH
//  BITS_PER_CYCLE  1   multiplier bits retired per CALC cycle; legal values 1, 2, 4
//                      (must divide WIDTH)
// PORTS
//  CLK             in   1          clock, rising edge
//  RST             in   1          reset, asynchronous, active-high (RST==1 resets)
//  MUL_START_I     in   1          request; sampled only in IDLE
//  MUL_CANCEL_I    in   1          abort the current operation; valid in any state
//  SIGNED_MUL_I    in   1          1 = two's-complement operands, 0 = unsigned
//  MULTIPLICAND_I  in   WIDTH      operand A
//  MULTIPLIER_I    in   WIDTH      operand B
//  MUL_READY_O     out  1          product valid; high exactly one cycle per operation
//  MUL_RESULT_O    out  2*WIDTH    registered product
//  BUSY_O          out  1          high in CALC and FIX states
// BEHAVIOUR
//  Reset (async)
//  - State goes to IDLE immediately.
//  - MUL_READY_O=0, MUL_RESULT_O=0, BUSY_O=0; all internal registers are cleared.
//  States: IDLE -> CALC -> FIX -> DONE -> IDLE
//  IDLE
//  - On START=1 and CANCEL=0: latch |A| and |B| (magnitudes when signed, raw when unsigned).
//  - Also latch neg = SIGNED & (A[W-1]^B[W-1]), clear the accumulator, set cnt=0, go to CALC.
//  - Otherwise stay in IDLE.
//  CALC
//  - Each cycle: acc += (B_lo_k * A) << (cnt*k), where k = BITS_PER_CYCLE.
//  - Then B >>= k and cnt++.
//  - After WIDTH/k cycles, go to FIX.
//  FIX
//  - MUL_RESULT_O <= neg ? (~acc + 1) : acc; go to DONE.
//  DONE
//  - MUL_READY_O=1 for this one cycle; unconditionally return to IDLE.
//  - MUL_RESULT_O holds its value until the next accepted START.
//  Latency
//  - START accepted at edge 0; READY is high in cycle WIDTH/k + 2.
//  - With defaults: 34 cycles from the accepting edge to the READY cycle.
//  Width rules
//  - Negation of a WIDTH-bit magnitude is done in WIDTH+1 bits, so the most negative
//    operand (0x80000000) is handled exactly.
//  - The accumulator is 2*WIDTH bits and never overflows.
//  Boundary conditions
//  - START while BUSY_O: ignored; the latched operands are not disturbed.
//  - CANCEL in CALC or FIX: next state is IDLE, READY stays 0, MUL_RESULT_O is unchanged.
//  - CANCEL in DONE: READY still pulses this cycle; next state is IDLE.
//  - START=1 in the DONE cycle is not accepted; it is re-sampled in the following IDLE cycle.
//  - RST mid-operation: abort at once and apply the reset values above.
//  - Operand B=0: runs the full iteration count unless the early-out feature is enabled;
//    result is 0.
// CONFIGURATION
//  MUL_EARLY_OUT_EN defined
//  - CALC exits to FIX at the end of any cycle in which the remaining shifted B is 0.
//  - At least one CALC cycle is always executed.
//  - Latency is data-dependent; the minimum is 3 cycles to READY.
//  MUL_EARLY_OUT_EN undefined
//  - Fixed WIDTH/k CALC cycles; latency is constant.
// TESTING
//  1 unsigned 0xFFFFFFFF*0xFFFFFFFF -> RESULT=0xFFFFFFFE_00000001; READY one cycle,
//    34 cycles after start
//  2 signed 0xFFFFFFFD(-3)*0x00000005 -> RESULT=0xFFFFFFFF_FFFFFFF1; low word 0xFFFFFFF1
//  3 signed 0x80000000*0x80000000 -> RESULT=0x40000000_00000000;
//    unsigned same operands -> RESULT=0x40000000_00000000
//  4 start 0x1234*0x10, CANCEL at CALC cycle 10 -> IDLE next cycle, no READY pulse,
//    RESULT unchanged; then start 7*6 -> RESULT=0x2A
//  5 RST pulsed at CALC cycle 5 -> READY=0, RESULT=0, BUSY=0 asynchronously;
//    a fresh 3*3 after release -> RESULT=9
//  6 MUL_EARLY_OUT_EN, unsigned 5*2 -> RESULT=0xA, READY 4 cycles after start;
//    without the macro -> 34 cycles

Source files
------------

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for the EX stage: retires BITS_PER_CYCLE multiplier bits per cycle.
// Optional MUL_EARLY_OUT_EN: leave CALC as soon as the remaining multiplier bits are zero.
module mul_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               MUL_START_I,
  input  logic               MUL_CANCEL_I,
  input  logic               SIGNED_MUL_I,
  input  logic [WIDTH-1:0]   MULTIPLICAND_I,
  input  logic [WIDTH-1:0]   MULTIPLIER_I,
  output logic               MUL_READY_O,
  output logic [2*WIDTH-1:0] MUL_RESULT_O,
  output logic               BUSY_O
);
  localparam int K     = BITS_PER_CYCLE;
  localparam int STEPS = WIDTH / K;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] a_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   b_q;
  logic               neg_q;
  logic [CW-1:0]      cnt_q;

  // Negation in WIDTH+1 bits keeps the most negative operand exact
  logic [WIDTH:0]     a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] partial, acc_nxt;
  logic [WIDTH-1:0]   b_nxt;
  logic               last;

  always_comb begin
    a_neg   = {1'b0, ~MULTIPLICAND_I} + (WIDTH+1)'(1);
    b_neg   = {1'b0, ~MULTIPLIER_I} + (WIDTH+1)'(1);
    a_mag   = (SIGNED_MUL_I && MULTIPLICAND_I[WIDTH-1]) ? a_neg[WIDTH-1:0] : MULTIPLICAND_I;
    b_mag   = (SIGNED_MUL_I && MULTIPLIER_I[WIDTH-1])   ? b_neg[WIDTH-1:0] : MULTIPLIER_I;
    // a_q is pre-shifted by cnt*K, so the partial product lands in place
    partial = a_q * (2*WIDTH)'(b_q[K-1:0]);
    acc_nxt = acc_q + partial;
    b_nxt   = b_q >> K;
`ifdef MUL_EARLY_OUT_EN
    last    = (b_nxt == '0) || (cnt_q == CW'(STEPS - 1));
`else
    last    = (cnt_q == CW'(STEPS - 1));
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      a_q          <= '0;
      acc_q        <= '0;
      b_q          <= '0;
      neg_q        <= 1'b0;
      cnt_q        <= '0;
      MUL_READY_O  <= 1'b0;
      MUL_RESULT_O <= '0;
    end else begin
      MUL_READY_O <= 1'b0;
      case (state)
        IDLE: if (MUL_START_I && !MUL_CANCEL_I) begin
          a_q   <= {{WIDTH{1'b0}}, a_mag};
          b_q   <= b_mag;
          neg_q <= SIGNED_MUL_I & (MULTIPLICAND_I[WIDTH-1] ^ MULTIPLIER_I[WIDTH-1]);
          acc_q <= '0;
          cnt_q <= '0;
          state <= CALC;
        end
        CALC: begin
          if (MUL_CANCEL_I) state <= IDLE;
          else begin
            acc_q <= acc_nxt;
            a_q   <= a_q << K;
            b_q   <= b_nxt;
            cnt_q <= cnt_q + CW'(1);
            if (last) state <= FIX;
          end
        end
        FIX: begin
          if (MUL_CANCEL_I) state <= IDLE;
          else begin
            MUL_RESULT_O <= neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
            MUL_READY_O  <= 1'b1;
            state        <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY_O = (state == CALC) || (state == FIX);
endmodule
